// File: rtl/fpcvt_arb.sv
// Two-requester round-robin front end that time-shares one 12-bit fixed-point
// to 8-bit floating-point converter (S, E[2:0], F[3:0]).

module fpcvt (
   input  logic [11:0] d,
   output logic        s,
   output logic [2:0]  e,
   output logic [3:0]  f
);
   logic [11:0] mag;
   logic [3:0]  pos;
   logic [3:0]  exp_r;
   logic [3:0]  sh_amt;
   logic [4:0]  sh5;
   logic [4:0]  sum;

   // Leading-one normalise, round half up on the first dropped bit.
   always_comb begin
      s      = d[11];
      mag    = d[11] ? (~d + 12'd1) : d;
      pos    = 4'd0;
      exp_r  = 4'd0;
      sh_amt = 4'd0;
      sh5    = 5'd0;
      sum    = 5'd0;
      e      = 3'd0;
      f      = 4'd0;
      for (int i = 0; i < 12; i++) begin
         if (mag[i]) pos = 4'(i);
      end
      if (mag >= 12'h7C0) begin
         e = 3'd7;
         f = 4'd15;
      end else if (mag < 12'd16) begin
         f = mag[3:0];
      end else begin
         exp_r  = pos - 4'd3;
         sh_amt = pos - 4'd4;
         sh5    = 5'(mag >> sh_amt);
         sum    = {1'b0, sh5[4:1]} + 5'(sh5[0]);
         if (sum[4]) begin
            e = 3'(exp_r + 4'd1);
            f = 4'd8;
         end else begin
            e = 3'(exp_r);
            f = sum[3:0];
         end
      end
   end
endmodule

module fpcvt_arb (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   input  logic [11:0] req_data0,
   input  logic [11:0] req_data1,
   output logic [1:0]  req_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_id,
   output logic        out_S,
   output logic [2:0]  out_E,
   output logic [3:0]  out_F,
   output logic [7:0]  conv_count
);
   localparam int unsigned DW = 12;
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

   state_t          state, state_nxt;
   logic [DW-1:0]   d_reg;
   logic            id_reg;
   logic            last_id;
   logic            grant_c, accept_c, capture_c, retire_c;
   logic            cvt_s;
   logic [2:0]      cvt_e;
   logic [3:0]      cvt_f;

   fpcvt u_fpcvt (
      .d (d_reg),
      .s (cvt_s),
      .e (cvt_e),
      .f (cvt_f)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Grant selection, handshake strobes and next state.
   always_comb begin
      state_nxt = state;
      grant_c   = 1'b0;
      accept_c  = 1'b0;
      capture_c = 1'b0;
      retire_c  = 1'b0;
      req_ready = 2'b00;
      case (state)
         IDLE: begin
            case (req_valid)
               2'b01:   grant_c = 1'b0;
               2'b10:   grant_c = 1'b1;
               default: grant_c = ~last_id;
            endcase
            if (rst_n && (req_valid != 2'b00)) begin
               accept_c  = 1'b1;
               req_ready = grant_c ? 2'b10 : 2'b01;
               state_nxt = CONV;
            end
         end
         CONV: begin
            capture_c = 1'b1;
            state_nxt = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               retire_c  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_reg      <= '0;
         id_reg     <= 1'b0;
         last_id    <= 1'b1;
         out_valid  <= 1'b0;
         out_id     <= 1'b0;
         out_S      <= 1'b0;
         out_E      <= 3'd0;
         out_F      <= 4'd0;
         conv_count <= '0;
      end else begin
         if (accept_c) begin
            d_reg   <= grant_c ? req_data1 : req_data0;
            id_reg  <= grant_c;
            last_id <= grant_c;
         end
         if (capture_c) begin
            out_valid <= 1'b1;
            out_id    <= id_reg;
            out_S     <= cvt_s;
            out_E     <= cvt_e;
            out_F     <= cvt_f;
         end
         if (retire_c) begin
            out_valid  <= 1'b0;
            conv_count <= conv_count + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_fpcvt_arb.sv
// Bench for fpcvt_arb: directed requests plus a per-cycle scoreboard monitor
// that predicts grants, latency, results and the conversion count.

module tb_fpcvt_arb;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [11:0] req_data0 = 12'd0;
   logic [11:0] req_data1 = 12'd0;
   logic [1:0]  req_ready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_id;
   logic        out_S;
   logic [2:0]  out_E;
   logic [3:0]  out_F;
   logic [7:0]  conv_count;

   int n_checks = 0;
   int n_fail   = 0;

   fpcvt_arb dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data0  (req_data0),
      .req_data1  (req_data1),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_id     (out_id),
      .out_S      (out_S),
      .out_E      (out_E),
      .out_F      (out_F),
      .conv_count (conv_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Value model: smallest exponent whose rounded quotient fits in 4 bits.
   function automatic logic [7:0] cvt_model(input logic [11:0] d);
      int mag, f;
      mag = d[11] ? 4096 - int'(d) : int'(d);
      for (int e = 0; e < 8; e++) begin
         f = (e == 0) ? mag : ((mag + (1 << (e - 1))) >> e);
         if (f <= 15) return {d[11], 3'(e), 4'(f)};
      end
      return {d[11], 7'h7F};
   endfunction

   logic [8:0] exp_q[$];
   logic       m_last = 1'b1;
   logic [7:0] m_count = 8'd0;
   int         cyc = 0;
   int         acc_cyc = 0;

   // Per-cycle scoreboard: expected ready, valid timing, result and count.
   always @(negedge clk) begin
      logic       busy, g, exp_valid;
      logic [1:0] exp_ready;
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         m_last  = 1'b1;
         m_count = 8'd0;
         chk("mon_rst_valid", 16'(out_valid), 16'd0);
         chk("mon_rst_ready", 16'(req_ready), 16'd0);
      end else begin
         busy      = (exp_q.size() != 0);
         exp_ready = 2'b00;
         g         = 1'b0;
         if (!busy) begin
            if (req_valid == 2'b01)      g = 1'b0;
            else if (req_valid == 2'b10) g = 1'b1;
            else                         g = ~m_last;
            if (req_valid != 2'b00) exp_ready = g ? 2'b10 : 2'b01;
         end
         chk("mon_ready", 16'(req_ready), 16'(exp_ready));
         exp_valid = busy && (cyc >= acc_cyc + 2);
         chk("mon_valid", 16'(out_valid), 16'(exp_valid));
         if (exp_valid && out_valid)
            chk("mon_result", 16'({out_id, out_S, out_E, out_F}), 16'(exp_q[0]));
         chk("mon_count", 16'(conv_count), 16'(m_count));
         if (exp_valid && out_ready) begin
            void'(exp_q.pop_front());
            m_count = m_count + 8'd1;
         end
         if (exp_ready != 2'b00) begin
            exp_q.push_back({g, cvt_model(g ? req_data1 : req_data0)});
            m_last  = g;
            acc_cyc = cyc;
         end
      end
   end

   task automatic run_one(input logic [1:0] v, input logic [11:0] d0, input logic [11:0] d1,
                          input logic [7:0] exp_sef, input logic exp_id, input int bp,
                          input logic [7:0] exp_cnt);
      bit got;
      @(posedge clk); #1;
      req_valid = v; req_data0 = d0; req_data1 = d1; out_ready = 1'b0;
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if ((req_ready & req_valid) != 2'b00) got = 1;
      end
      chk("accept_seen", 16'(got), 16'd1);
      @(posedge clk); #1;
      req_valid = 2'b00;
      req_data0 = 12'($urandom);
      req_data1 = 12'($urandom);
      out_ready = (bp == 0);
      @(negedge clk);
      chk("conv_no_valid", 16'(out_valid), 16'd0);
      @(negedge clk);
      chk("res_valid", 16'(out_valid), 16'd1);
      chk("res_sef", 16'({out_S, out_E, out_F}), 16'(exp_sef));
      chk("res_id", 16'(out_id), 16'(exp_id));
      if (bp > 0) begin
         @(posedge clk); #1;
         req_valid = 2'b11;
         for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_valid", 16'(out_valid), 16'd1);
            chk("bp_sef", 16'({out_S, out_E, out_F}), 16'(exp_sef));
            chk("bp_id", 16'(out_id), 16'(exp_id));
            chk("bp_ready", 16'(req_ready), 16'd0);
            chk("bp_count", 16'(conv_count), 16'(exp_cnt - 8'd1));
         end
         @(posedge clk); #1;
         req_valid = 2'b00;
         out_ready = 1'b1;
         @(negedge clk);
         chk("bp_last_valid", 16'(out_valid), 16'd1);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("done_valid", 16'(out_valid), 16'd0);
      chk("done_count", 16'(conv_count), 16'(exp_cnt));
   endtask

   initial begin
      logic ids[4];
      int   n;

      chk("model_00A", 16'(cvt_model(12'h00A)), 16'h0A);
      chk("model_07D", 16'(cvt_model(12'h07D)), 16'h48);
      chk("model_800", 16'(cvt_model(12'h800)), 16'hFF);
      chk("model_7C0", 16'(cvt_model(12'h7C0)), 16'h7F);
      chk("model_7BF", 16'(cvt_model(12'h7BF)), 16'h7F);

      #27;
      chk("rst_out_valid", 16'(out_valid), 16'd0);
      chk("rst_count", 16'(conv_count), 16'd0);
      chk("rst_sef_id", 16'({out_id, out_S, out_E, out_F}), 16'd0);
      req_valid = 2'b11;
      #1;
      chk("rst_ready", 16'(req_ready), 16'd0);
      req_valid = 2'b00;
      @(negedge clk); #2;
      rst_n = 1'b1;

      run_one(2'b01, 12'h00A, 12'h000, 8'h0A, 1'b0, 0, 8'd1);
      run_one(2'b10, 12'h000, 12'h07D, 8'h48, 1'b1, 0, 8'd2);
      run_one(2'b01, 12'h800, 12'h000, 8'hFF, 1'b0, 0, 8'd3);
      run_one(2'b01, 12'h7C0, 12'h000, 8'h7F, 1'b0, 0, 8'd4);
      run_one(2'b10, 12'h000, 12'hFFB, 8'h85, 1'b1, 10, 8'd5);
      run_one(2'b10, 12'h000, 12'h0F8, 8'h58, 1'b1, 0, 8'd6);
      run_one(2'b11, 12'h010, 12'h07D, 8'h18, 1'b0, 0, 8'd7);
      run_one(2'b11, 12'h010, 12'h000, 8'h00, 1'b1, 0, 8'd8);

      // Contention with continuous downstream acceptance.
      @(posedge clk); #1;
      req_valid = 2'b11; req_data0 = 12'h00A; req_data1 = 12'h07D; out_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            ids[n] = out_id;
            n++;
         end
      end
      chk("rr_results", 16'(n), 16'd4);
      for (int i = 0; i < 4; i++) chk("rr_order", 16'(ids[i]), 16'(i % 2));
      @(posedge clk); #1;
      req_valid = 2'b00; out_ready = 1'b0;
      @(negedge clk);
      chk("rr_count", 16'(conv_count), 16'd12);

      // Reset while a conversion is in CONV.
      @(posedge clk); #1;
      req_valid = 2'b01; req_data0 = 12'h00A;
      @(posedge clk); #1;
      req_valid = 2'b00;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 16'(out_valid), 16'd0);
      chk("midrst_count", 16'(conv_count), 16'd0);
      chk("midrst_ready", 16'(req_ready), 16'd0);
      @(negedge clk); #2;
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_abandoned", 16'(out_valid), 16'd0);
      run_one(2'b11, 12'hFFB, 12'h07D, 8'h85, 1'b0, 0, 8'd1);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fpcvt_arb.md
FPCVT_ARB -- requirements
Module: fpcvt_arb

Interface
REQ-001 SHALL have these ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  per-requester request valid; bit i is requester i.
- req_data0  input  12  requester 0 two's-complement sample.
- req_data1  input  12  requester 1 two's-complement sample.
- req_ready  output  2  per-requester accept strobe; a request transfers when valid and ready are both high at a clock edge.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_id  output  1  index of the requester that owns the result.
- out_S  output  1  sign of the result.
- out_E  output  3  exponent of the result.
- out_F  output  4  significand of the result.
- conv_count  output  8  count of completed conversions.
REQ-002 SHALL treat one clock and an asynchronous, active-low reset as decided: ports clk and rst_n.

Function
REQ-003 SHALL instantiate exactly one FPCVT (D[11:0] -> S, E[2:0], F[3:0]) and time-share it between the two requesters.
REQ-004 SHALL implement FSM states IDLE, CONV and HOLD.
REQ-005 In IDLE, SHALL assert req_ready[g] combinationally for the granted requester g only, and only when req_valid[g]=1; the other req_ready bit SHALL be 0.
REQ-006 SHALL choose the grant round-robin:
- if exactly one req_valid bit is set, grant that requester;
- if both are set, grant the requester not recorded in last_id.
REQ-007 SHALL hold last_id in a register, update it to g on each accepted request, and reset it to 1 so requester 0 wins the first tie.
REQ-008 On an accepted request in IDLE, SHALL at the same edge:
- latch the selected req_data into the 12-bit D register;
- latch g into the id register;
- go to CONV.
REQ-009 In CONV, SHALL hold req_ready at 0, capture the FPCVT outputs for the D register into out_S/out_E/out_F at the next edge, set out_valid=1 and go to HOLD.
REQ-010 In HOLD, SHALL keep out_valid, out_id, out_S, out_E and out_F stable until out_ready=1 is sampled.
REQ-011 At an edge in HOLD with out_ready=1, SHALL:
- clear out_valid;
- increment conv_count by 1 (wrapping 255 -> 0);
- return to IDLE.
REQ-012 SHALL NOT accept a new request on the edge where HOLD exits; minimum spacing is 3 cycles per conversion.
REQ-013 Latency: result SHALL be valid 2 edges after acceptance (accept edge N, out_valid high after edge N+1).
REQ-014 SHALL ignore req_data and req_valid changes after acceptance until the FSM is back in IDLE.
REQ-015 SHALL keep out_ready ignored while out_valid=0.
REQ-016 SHALL implement the conversion contract via FPCVT:
- sign = D[11];
- magnitude is the two's complement of D when negative;
- magnitude >= 12'h7C0 (including 12'h800) saturates to E=7, F=15;
- otherwise round-half-up on the first discarded bit;
- on significand overflow, F is shifted right and E is incremented.

Reset
REQ-017 While rst_n=0, SHALL force asynchronously:
- FSM to IDLE;
- out_valid=0, out_id=0, out_S=0, out_E=0, out_F=0;
- conv_count=0, last_id=1, D register=0;
- req_ready=2'b00.
REQ-018 Reset asserted in CONV or HOLD SHALL abandon the in-flight conversion with no result delivered and no count increment.
REQ-019 After rst_n deasserts, SHALL accept requests from the first rising edge.

Verification
REQ-020 Single request: req_valid=01, req_data0=12'h00A -> req_ready=01 for one cycle; 2 edges later {S,E,F}=8'h0A, out_id=0.
REQ-021 Rounding overflow: req_data1=12'h07D -> {S,E,F}=8'h48 (E=4, F=8), out_id=1.
REQ-022 Saturation: req_data0=12'h800 -> 8'hFF; req_data0=12'h7C0 -> 8'h7F.
REQ-023 Contention: both valid continuously, out_ready=1 -> grants alternate 0,1,0,1; conv_count=4 after four results; no requester starved.
REQ-024 Backpressure: out_ready=0 for 10 cycles in HOLD -> outputs stable, req_ready=00, conv_count unchanged; then out_ready=1 -> count +1 and IDLE next cycle.
REQ-025 Reset mid-operation: rst_n low in CONV -> out_valid=0 immediately; conv_count=0; next tie grants requester 0.
